reg_file_8x16: RTL

- Architectural register file that consumes the register-file input selects: ReadA/ReadB addresses, WriteReg, WriteValue, and a write enable.
- Holds eight 16-bit registers r0..r7; all are writable, with no hardwired zero.
- Provides two combinational read ports with write-through bypass, plus a dedicated RegFive tap for the lmhw byte-merge path.
- Includes a debug dump engine that streams all eight registers out under a valid/ready handshake.

---
 rtl/reg_file_8x16_pkg.sv | 16 +
 rtl/reg_file_8x16_reg_dump_ctrl.sv | 60 ++++++
 rtl/reg_file_8x16.sv | 51 +++++
 3 files changed

// File: rtl/reg_file_8x16_pkg.sv
// reg_file_8x16_pkg: shared register-file constants, register names and dump FSM encoding
package reg_file_8x16_pkg;
    localparam int REG_W      = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;
    localparam logic [REG_ADDR_W-1:0] R_ZERO = 3'd0;
    localparam logic [REG_ADDR_W-1:0] R_ONE  = 3'd1;
    localparam logic [REG_ADDR_W-1:0] R_FIVE = 3'd5;
    localparam logic [REG_ADDR_W-1:0] R_SP   = 3'd6;
    localparam logic [REG_ADDR_W-1:0] R_RA   = 3'd7;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_e;
endpackage

// File: rtl/reg_file_8x16_reg_dump_ctrl.sv
// reg_dump_ctrl: streams every register out in index order over a valid/ready handshake
module reg_dump_ctrl
    import reg_file_8x16_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              ready,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_idx,
    output logic              valid,
    output logic [ADDR_W-1:0] idx,
    output logic [DATA_W-1:0] data,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(2**ADDR_W - 1);
    dump_state_e state;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state <= SEND;
                    idx   <= '0;
                    valid <= 1'b1;
                    busy  <= 1'b1;
                end
                SEND: if (ready) begin
                    if (idx == LAST) begin
                        state <= DONE;
                        valid <= 1'b0;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
    // Data follows live storage so a stalled word picks up later writes
    assign rd_idx = idx;
    assign data   = valid ? rd_data : '0;
endmodule

// File: rtl/reg_file_8x16.sv
// reg_file_8x16: eight-entry register file with bypassed read ports, r5 tap and debug dump
module reg_file_8x16
    import reg_file_8x16_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ReadA,
    input  logic [ADDR_W-1:0] ReadB,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteValue,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] RegAOut,
    output logic [DATA_W-1:0] RegBOut,
    output logic [DATA_W-1:0] RegFive,
    input  logic              DumpReq,
    output logic              DumpValid,
    input  logic              DumpReady,
    output logic [ADDR_W-1:0] DumpIdx,
    output logic [DATA_W-1:0] DumpData,
    output logic              DumpBusy
);
    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic [ADDR_W-1:0] dump_rd_idx;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else if (RegWrite) begin
            regs[WriteReg] <= WriteValue;
        end
    end
    assign RegAOut = (BYPASS && RegWrite && ReadA == WriteReg) ? WriteValue : regs[ReadA];
    assign RegBOut = (BYPASS && RegWrite && ReadB == WriteReg) ? WriteValue : regs[ReadB];
    // The lmhw merge must see the committed value, so this tap never bypasses
    assign RegFive = regs[ADDR_W'(R_FIVE)];
    reg_dump_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dump (
        .clk     (clk),
        .reset   (reset),
        .req     (DumpReq),
        .ready   (DumpReady),
        .rd_data (regs[dump_rd_idx]),
        .rd_idx  (dump_rd_idx),
        .valid   (DumpValid),
        .idx     (DumpIdx),
        .data    (DumpData),
        .busy    (DumpBusy)
    );
endmodule
